// File: rtl/rs_issue_scheduler_if.sv
// Bundle between the IDU, the CDB release path and the add/mul reservation stations.
// The scheduler sits on the slave modport; the IDU/RS/CDB environment sits on master.
interface rs_issue_scheduler_if #(
    parameter int TAG_W = 2
);
    // Handshake: a pair transfers on a rising edge where in_valid && in_ready.
    // in_valid may be raised at any time and holds its pair until accepted.
    // in_ready is combinational and may depend on the held pair and on flush.
    // Issue strobes (iss*_valid, select_instruction) are one-cycle pulses with no back-pressure.
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_inst1_type;
    logic [7:0]       in_inst2_type;
    logic             flush;
    logic             add_rel_valid;
    logic [TAG_W-1:0] add_rel_tag;
    logic             mul_rel_valid;
    logic [TAG_W-1:0] mul_rel_tag;
    logic [1:0]       select_instruction;
    logic             iss1_valid;
    logic             iss2_valid;
    logic [7:0]       iss1_type;
    logic [7:0]       iss2_type;
    logic [TAG_W:0]   iss1_rs_id;
    logic [TAG_W:0]   iss2_rs_id;
    logic             AR_Status;
    logic             MR_Status;
    logic             rel_err;

    modport slave (
        input  in_valid, in_inst1_type, in_inst2_type, flush,
               add_rel_valid, add_rel_tag, mul_rel_valid, mul_rel_tag,
        output in_ready, select_instruction, iss1_valid, iss2_valid,
               iss1_type, iss2_type, iss1_rs_id, iss2_rs_id,
               AR_Status, MR_Status, rel_err
    );

    modport master (
        output in_valid, in_inst1_type, in_inst2_type, flush,
               add_rel_valid, add_rel_tag, mul_rel_valid, mul_rel_tag,
        input  in_ready, select_instruction, iss1_valid, iss2_valid,
               iss1_type, iss2_type, iss1_rs_id, iss2_rs_id,
               AR_Status, MR_Status, rel_err
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// In-order dual-issue scheduler: holds one decoded pair, allocates lowest free add/mul RS
// slots, tracks busy bits freed by CDB release and reports full flags back to the IDU.
module rs_issue_scheduler #(
    parameter int         ADD_RS_DEPTH = 3,
    parameter int         MUL_RS_DEPTH = 2,
    parameter int         TAG_W        = 2,
    parameter logic [7:0] OP_ADD       = 8'h01,
    parameter logic [7:0] OP_SUB       = 8'h02,
    parameter logic [7:0] OP_MUL       = 8'h03,
    parameter logic [7:0] OP_DIV       = 8'h04
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rs_issue_scheduler_if.slave     bus,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_PAIR   = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;

    logic [1:0]              state;
    logic [7:0]              inst1_q;
    logic [7:0]              inst2_q;
    logic [ADD_RS_DEPTH-1:0] add_busy;
    logic [MUL_RS_DEPTH-1:0] mul_busy;

    logic [1:0]       sel_q;
    logic             iss1_valid_q, iss2_valid_q;
    logic [7:0]       iss1_type_q, iss2_type_q;
    logic [TAG_W:0]   iss1_id_q, iss2_id_q;
    logic             ar_q, mr_q, rel_err_q;

    function automatic logic is_add(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_mul(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Lowest and second-lowest free slot of each class, from registered busy bits only.
    logic             a_f1, a_f2, m_f1, m_f2;
    logic [TAG_W-1:0] a_i1, a_i2, m_i1, m_i2;

    always_comb begin
        a_f1 = 1'b0; a_f2 = 1'b0; a_i1 = '0; a_i2 = '0;
        for (int i = 0; i < ADD_RS_DEPTH; i++) begin
            if (!add_busy[i]) begin
                if (!a_f1) begin
                    a_f1 = 1'b1; a_i1 = TAG_W'(i);
                end else if (!a_f2) begin
                    a_f2 = 1'b1; a_i2 = TAG_W'(i);
                end
            end
        end
    end

    always_comb begin
        m_f1 = 1'b0; m_f2 = 1'b0; m_i1 = '0; m_i2 = '0;
        for (int i = 0; i < MUL_RS_DEPTH; i++) begin
            if (!mul_busy[i]) begin
                if (!m_f1) begin
                    m_f1 = 1'b1; m_i1 = TAG_W'(i);
                end else if (!m_f2) begin
                    m_f2 = 1'b1; m_i2 = TAG_W'(i);
                end
            end
        end
    end

    logic             a1, m1, a2, m2;
    logic             in_pair, in_second;
    logic             can1, can2, share_add, share_mul;
    logic [TAG_W-1:0] idx1, idx2;
    logic             go1, go2, drain, take, ready;

    assign a1        = is_add(inst1_q);
    assign m1        = is_mul(inst1_q);
    assign a2        = is_add(inst2_q);
    assign m2        = is_mul(inst2_q);
    assign in_pair   = (state == ST_PAIR);
    assign in_second = (state == ST_SECOND);

    // inst2 must skip the slot inst1 is taking when both target the same class.
    assign share_add = in_pair & a1;
    assign share_mul = in_pair & m1;
    assign can1      = a1 ? a_f1 : (m1 ? m_f1 : 1'b1);
    assign idx1      = a1 ? a_i1 : m_i1;
    assign can2      = a2 ? (share_add ? a_f2 : a_f1) :
                       (m2 ? (share_mul ? m_f2 : m_f1) : 1'b1);
    assign idx2      = a2 ? (share_add ? a_i2 : a_i1) : (share_mul ? m_i2 : m_i1);

    assign go1   = ~bus.flush & in_pair & can1;
    assign go2   = ~bus.flush & ((in_pair & can1 & can2) | (in_second & can2));
    assign drain = (in_pair & go1 & go2) | (in_second & go2);
    assign ready = rst_n & ~bus.flush & ((state == ST_EMPTY) | drain);
    assign take  = bus.in_valid & ready;

    logic [ADD_RS_DEPTH-1:0] add_alloc, add_rel, add_next;
    logic [MUL_RS_DEPTH-1:0] mul_alloc, mul_rel, mul_next;
    logic                    rel_bad;

    always_comb begin
        add_alloc = '0;
        add_rel   = '0;
        for (int i = 0; i < ADD_RS_DEPTH; i++) begin
            if ((go1 & a1 & (idx1 == TAG_W'(i))) | (go2 & a2 & (idx2 == TAG_W'(i))))
                add_alloc[i] = 1'b1;
            if (bus.add_rel_valid & (bus.add_rel_tag == TAG_W'(i)) & add_busy[i])
                add_rel[i] = 1'b1;
        end
        mul_alloc = '0;
        mul_rel   = '0;
        for (int i = 0; i < MUL_RS_DEPTH; i++) begin
            if ((go1 & m1 & (idx1 == TAG_W'(i))) | (go2 & m2 & (idx2 == TAG_W'(i))))
                mul_alloc[i] = 1'b1;
            if (bus.mul_rel_valid & (bus.mul_rel_tag == TAG_W'(i)) & mul_busy[i])
                mul_rel[i] = 1'b1;
        end
    end

    // A release that matched no busy in-range slot leaves its mask empty.
    assign rel_bad  = (bus.add_rel_valid & (add_rel == '0)) |
                      (bus.mul_rel_valid & (mul_rel == '0));
    assign add_next = (add_busy & ~add_rel) | add_alloc;
    assign mul_next = (mul_busy & ~mul_rel) | mul_alloc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            inst1_q      <= '0;
            inst2_q      <= '0;
            add_busy     <= '0;
            mul_busy     <= '0;
            sel_q        <= '0;
            iss1_valid_q <= 1'b0;
            iss2_valid_q <= 1'b0;
            iss1_type_q  <= '0;
            iss2_type_q  <= '0;
            iss1_id_q    <= '0;
            iss2_id_q    <= '0;
            ar_q         <= 1'b0;
            mr_q         <= 1'b0;
            rel_err_q    <= 1'b0;
        end else begin
            if (bus.flush)               state <= ST_EMPTY;
            else if (take)               state <= ST_PAIR;
            else if (drain)              state <= ST_EMPTY;
            else if (in_pair & go1)      state <= ST_SECOND;

            if (take) begin
                inst1_q <= bus.in_inst1_type;
                inst2_q <= bus.in_inst2_type;
            end

            add_busy     <= add_next;
            mul_busy     <= mul_next;
            sel_q        <= {go2, go1};
            iss1_valid_q <= go1 & (a1 | m1);
            iss2_valid_q <= go2 & (a2 | m2);
            iss1_type_q  <= (go1 & (a1 | m1)) ? inst1_q : 8'h00;
            iss2_type_q  <= (go2 & (a2 | m2)) ? inst2_q : 8'h00;
            iss1_id_q    <= (go1 & (a1 | m1)) ? {m1, idx1} : '0;
            iss2_id_q    <= (go2 & (a2 | m2)) ? {m2, idx2} : '0;
            ar_q         <= &add_next;
            mr_q         <= &mul_next;
            rel_err_q    <= rel_err_q | rel_bad;
        end
    end

    assign bus.in_ready           = ready;
    assign bus.select_instruction = sel_q;
    assign bus.iss1_valid         = iss1_valid_q;
    assign bus.iss2_valid         = iss2_valid_q;
    assign bus.iss1_type          = iss1_type_q;
    assign bus.iss2_type          = iss2_type_q;
    assign bus.iss1_rs_id         = iss1_id_q;
    assign bus.iss2_rs_id         = iss2_id_q;
    assign bus.AR_Status          = ar_q;
    assign bus.MR_Status          = mr_q;
    assign bus.rel_err            = rel_err_q;
    assign dbg_state              = state;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: reset, dual issue, back-to-back capture, stalls,
// release reuse, NOP handling, release errors, flush and mid-operation reset.
module tb_rs_issue_scheduler;
  localparam int TAG_W = 2;
  localparam logic [7:0] ADD = 8'h01, SUB = 8'h02, MUL = 8'h03, DIV = 8'h04, NOP = 8'h00;
  localparam logic [1:0] S_EMPTY = 2'd0, S_PAIR = 2'd1, S_SECOND = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int n_cmp = 0;
  int n_err = 0;

  rs_issue_scheduler_if #(.TAG_W(TAG_W)) bus ();

  rs_issue_scheduler #(.ADD_RS_DEPTH(3), .MUL_RS_DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_inst1_type = 8'h00;
    bus.in_inst2_type = 8'h00;
    bus.flush = 1'b0;
    bus.add_rel_valid = 1'b0;
    bus.add_rel_tag = '0;
    bus.mul_rel_valid = 1'b0;
    bus.mul_rel_tag = '0;
  endtask

  task automatic send_pair(input logic [7:0] t1, input logic [7:0] t2);
    bus.in_valid = 1'b1;
    bus.in_inst1_type = t1;
    bus.in_inst2_type = t2;
  endtask

  task automatic stop_pair();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    step();
    n_cmp++; if (dbg_state !== S_EMPTY) begin n_err++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_EMPTY); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.select_instruction !== 2'b00) begin n_err++; $display("FAIL rst_select got=%b exp=00", bus.select_instruction); end
    n_cmp++; if ({bus.iss1_valid, bus.iss2_valid} !== 2'b00) begin n_err++; $display("FAIL rst_iss_valid got=%b exp=00", {bus.iss1_valid, bus.iss2_valid}); end
    n_cmp++; if ({bus.AR_Status, bus.MR_Status, bus.rel_err} !== 3'b000) begin n_err++; $display("FAIL rst_status got=%b exp=000", {bus.AR_Status, bus.MR_Status, bus.rel_err}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_dual_issue();
    do_reset();
    send_pair(ADD, MUL);
    step();
    stop_pair();
    n_cmp++; if (dbg_state !== S_PAIR) begin n_err++; $display("FAIL t1_state_capture got=%0d exp=%0d", dbg_state, S_PAIR); end
    n_cmp++; if (bus.select_instruction !== 2'b00) begin n_err++; $display("FAIL t1_select_capture got=%b exp=00", bus.select_instruction); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready_drain got=%b exp=1", bus.in_ready); end
    step();
    n_cmp++; if (bus.select_instruction !== 2'b11) begin n_err++; $display("FAIL t1_select got=%b exp=11", bus.select_instruction); end
    n_cmp++; if (bus.iss1_rs_id !== 3'b000 || bus.iss2_rs_id !== 3'b100) begin n_err++; $display("FAIL t1_ids got=%b,%b exp=000,100", bus.iss1_rs_id, bus.iss2_rs_id); end
    n_cmp++; if (bus.iss1_type !== ADD || bus.iss2_type !== MUL) begin n_err++; $display("FAIL t1_types got=%h,%h exp=01,03", bus.iss1_type, bus.iss2_type); end
    n_cmp++; if ({bus.iss1_valid, bus.iss2_valid} !== 2'b11) begin n_err++; $display("FAIL t1_iss_valid got=%b exp=11", {bus.iss1_valid, bus.iss2_valid}); end
    n_cmp++; if ({bus.AR_Status, bus.MR_Status} !== 2'b00 || dbg_state !== S_EMPTY) begin n_err++; $display("FAIL t1_status got=%b state=%0d exp=00 state=0", {bus.AR_Status, bus.MR_Status}, dbg_state); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_pair(ADD, SUB);
    step();
    send_pair(ADD, ADD);
    step();
    stop_pair();
    n_cmp++; if (bus.select_instruction !== 2'b11) begin n_err++; $display("FAIL t2_select1 got=%b exp=11", bus.select_instruction); end
    n_cmp++; if (bus.iss1_rs_id !== 3'b000 || bus.iss2_rs_id !== 3'b001) begin n_err++; $display("FAIL t2_ids1 got=%b,%b exp=000,001", bus.iss1_rs_id, bus.iss2_rs_id); end
    n_cmp++; if (dbg_state !== S_PAIR) begin n_err++; $display("FAIL t2_recapture got=%0d exp=%0d", dbg_state, S_PAIR); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t2_ready_partial got=%b exp=0", bus.in_ready); end
    step();
    n_cmp++; if (bus.select_instruction !== 2'b01) begin n_err++; $display("FAIL t2_select2 got=%b exp=01", bus.select_instruction); end
    n_cmp++; if (bus.iss1_rs_id !== 3'b010 || bus.iss1_valid !== 1'b1 || bus.iss2_valid !== 1'b0) begin n_err++; $display("FAIL t2_id3 got=%b v=%b%b exp=010 v=10", bus.iss1_rs_id, bus.iss1_valid, bus.iss2_valid); end
    n_cmp++; if (dbg_state !== S_SECOND || bus.AR_Status !== 1'b1) begin n_err++; $display("FAIL t2_full got state=%0d ar=%b exp state=2 ar=1", dbg_state, bus.AR_Status); end
    step();
    n_cmp++; if (bus.select_instruction !== 2'b00 || dbg_state !== S_SECOND) begin n_err++; $display("FAIL t2_wait got=%b state=%0d exp=00 state=2", bus.select_instruction, dbg_state); end
  endtask

  task automatic test_release_reuse();
    bus.add_rel_valid = 1'b1;
    bus.add_rel_tag = 2'd1;
    step();
    bus.add_rel_valid = 1'b0;
    n_cmp++; if (bus.select_instruction !== 2'b00 || dbg_state !== S_SECOND) begin n_err++; $display("FAIL t3_no_bypass got=%b state=%0d exp=00 state=2", bus.select_instruction, dbg_state); end
    step();
    n_cmp++; if (bus.select_instruction !== 2'b10) begin n_err++; $display("FAIL t3_select got=%b exp=10", bus.select_instruction); end
    n_cmp++; if (bus.iss2_rs_id !== 3'b001 || bus.iss2_valid !== 1'b1 || bus.iss1_valid !== 1'b0) begin n_err++; $display("FAIL t3_id got=%b v=%b%b exp=001 v=01", bus.iss2_rs_id, bus.iss1_valid, bus.iss2_valid); end
    n_cmp++; if (bus.AR_Status !== 1'b1 || dbg_state !== S_EMPTY || bus.rel_err !== 1'b0) begin n_err++; $display("FAIL t3_status got ar=%b state=%0d err=%b exp ar=1 state=0 err=0", bus.AR_Status, dbg_state, bus.rel_err); end
  endtask

  task automatic test_in_order_stall();
    do_reset();
    send_pair(MUL, DIV);
    step();
    send_pair(MUL, ADD);
    step();
    stop_pair();
    n_cmp++; if (bus.iss1_rs_id !== 3'b100 || bus.iss2_rs_id !== 3'b101 || bus.MR_Status !== 1'b1) begin n_err++; $display("FAIL t4_fill got=%b,%b mr=%b exp=100,101 mr=1", bus.iss1_rs_id, bus.iss2_rs_id, bus.MR_Status); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_stall got=%b exp=0", bus.in_ready); end
    step();
    n_cmp++; if (bus.select_instruction !== 2'b00 || dbg_state !== S_PAIR) begin n_err++; $display("FAIL t4_in_order got=%b state=%0d exp=00 state=1", bus.select_instruction, dbg_state); end
    bus.mul_rel_valid = 1'b1;
    bus.mul_rel_tag = 2'd0;
    step();
    bus.mul_rel_valid = 1'b0;
    n_cmp++; if (bus.select_instruction !== 2'b00 || bus.MR_Status !== 1'b0) begin n_err++; $display("FAIL t4_release got=%b mr=%b exp=00 mr=0", bus.select_instruction, bus.MR_Status); end
    step();
    n_cmp++; if (bus.select_instruction !== 2'b11) begin n_err++; $display("FAIL t4_select got=%b exp=11", bus.select_instruction); end
    n_cmp++; if (bus.iss1_rs_id !== 3'b100 || bus.iss2_rs_id !== 3'b000 || bus.iss2_type !== ADD) begin n_err++; $display("FAIL t4_ids got=%b,%b type2=%h exp=100,000 type2=01", bus.iss1_rs_id, bus.iss2_rs_id, bus.iss2_type); end
    n_cmp++; if ({bus.AR_Status, bus.MR_Status} !== 2'b01 || dbg_state !== S_EMPTY) begin n_err++; $display("FAIL t4_status got=%b state=%0d exp=01 state=0", {bus.AR_Status, bus.MR_Status}, dbg_state); end
  endtask

  task automatic test_nop();
    do_reset();
    send_pair(NOP, ADD);
    step();
    stop_pair();
    step();
    n_cmp++; if (bus.select_instruction !== 2'b11) begin n_err++; $display("FAIL nop_select got=%b exp=11", bus.select_instruction); end
    n_cmp++; if (bus.iss1_valid !== 1'b0 || bus.iss2_valid !== 1'b1 || bus.iss2_rs_id !== 3'b000) begin n_err++; $display("FAIL nop_iss got v=%b%b id2=%b exp v=01 id2=000", bus.iss1_valid, bus.iss2_valid, bus.iss2_rs_id); end
  endtask

  task automatic test_rel_err();
    do_reset();
    bus.mul_rel_valid = 1'b1;
    bus.mul_rel_tag = 2'd1;
    step();
    bus.mul_rel_valid = 1'b0;
    n_cmp++; if (bus.rel_err !== 1'b1 || bus.MR_Status !== 1'b0) begin n_err++; $display("FAIL t5_err got err=%b mr=%b exp err=1 mr=0", bus.rel_err, bus.MR_Status); end
    step();
    n_cmp++; if (bus.rel_err !== 1'b1) begin n_err++; $display("FAIL t5_sticky got=%b exp=1", bus.rel_err); end
    send_pair(MUL, MUL);
    step();
    stop_pair();
    step();
    n_cmp++; if (bus.select_instruction !== 2'b11 || bus.iss1_rs_id !== 3'b100 || bus.iss2_rs_id !== 3'b101) begin n_err++; $display("FAIL t5_busy got=%b ids=%b,%b exp=11 ids=100,101", bus.select_instruction, bus.iss1_rs_id, bus.iss2_rs_id); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rel_err !== 1'b0 || bus.MR_Status !== 1'b0) begin n_err++; $display("FAIL t5_async_clear got err=%b mr=%b exp err=0 mr=0", bus.rel_err, bus.MR_Status); end
    rst_n = 1'b1;
    bus.add_rel_valid = 1'b1;
    bus.add_rel_tag = 2'd3;
    step();
    bus.add_rel_valid = 1'b0;
    n_cmp++; if (bus.rel_err !== 1'b1 || bus.AR_Status !== 1'b0) begin n_err++; $display("FAIL t5_range got err=%b ar=%b exp err=1 ar=0", bus.rel_err, bus.AR_Status); end
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    send_pair(ADD, MUL);
    step();
    bus.flush = 1'b1;
    send_pair(SUB, DIV);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t6_flush_ready got=%b exp=0", bus.in_ready); end
    step();
    bus.flush = 1'b0;
    stop_pair();
    n_cmp++; if (dbg_state !== S_EMPTY || bus.select_instruction !== 2'b00) begin n_err++; $display("FAIL t6_flush got state=%0d sel=%b exp state=0 sel=00", dbg_state, bus.select_instruction); end
    n_cmp++; if ({bus.iss1_valid, bus.iss2_valid} !== 2'b00) begin n_err++; $display("FAIL t6_flush_iss got=%b exp=00", {bus.iss1_valid, bus.iss2_valid}); end
    send_pair(ADD, ADD);
    step();
    stop_pair();
    step();
    n_cmp++; if (bus.iss1_rs_id !== 3'b000 || bus.iss2_rs_id !== 3'b001 || bus.MR_Status !== 1'b0) begin n_err++; $display("FAIL t6_busy_kept got=%b,%b mr=%b exp=000,001 mr=0", bus.iss1_rs_id, bus.iss2_rs_id, bus.MR_Status); end
    send_pair(MUL, MUL);
    step();
    send_pair(MUL, DIV);
    step();
    stop_pair();
    step();
    n_cmp++; if (dbg_state !== S_PAIR || bus.MR_Status !== 1'b1) begin n_err++; $display("FAIL t6_stall got state=%0d mr=%b exp state=1 mr=1", dbg_state, bus.MR_Status); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== S_EMPTY || bus.in_ready !== 1'b0 || {bus.AR_Status, bus.MR_Status} !== 2'b00) begin n_err++; $display("FAIL t6_mid_reset got state=%0d rdy=%b st=%b exp state=0 rdy=0 st=00", dbg_state, bus.in_ready, {bus.AR_Status, bus.MR_Status}); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (dbg_state !== S_EMPTY || bus.select_instruction !== 2'b00) begin n_err++; $display("FAIL t6_pair_lost got state=%0d sel=%b exp state=0 sel=00", dbg_state, bus.select_instruction); end
    send_pair(DIV, MUL);
    step();
    stop_pair();
    step();
    n_cmp++; if (bus.iss1_rs_id !== 3'b100 || bus.iss2_rs_id !== 3'b101 || bus.iss1_type !== DIV) begin n_err++; $display("FAIL t6_after_reset got=%b,%b type1=%h exp=100,101 type1=04", bus.iss1_rs_id, bus.iss2_rs_id, bus.iss1_type); end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_back_to_back();
    test_release_reuse();
    test_in_order_stall();
    test_nop();
    test_rel_err();
    test_flush_and_reset();
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
